// File: rtl/display_pkg.sv
// Shared definitions for the front-panel display path: frame geometry,
// sequencer state encoding and fixed phase lengths.
package display_pkg;

    localparam int ROW_W         = 24;
    localparam int FRAME_W       = 3 * ROW_W;
    localparam int CLEAR_CYCLES  = 4;
    localparam int SETTLE_CYCLES = 3;

    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_BLANK   = 3'd3,
        ST_SHIFT   = 3'd4,
        ST_LOAD    = 3'd5,
        ST_HOLD    = 3'd6
    } disp_state_e;

endpackage

// File: rtl/sclk_tick_gen.sv
// Restartable clock divider: one-cycle tick every CLK_DIV enabled cycles,
// counter parked at zero while disabled or restarted.
module sclk_tick_gen
    import display_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] cnt_q;

    // Next divider count and terminal-count tick.
    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (restart || !en) begin
            cnt_d = '0;
        end else if (cnt_q == DIV_LAST) begin
            tick  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Divider count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_shift_driver.sv
// Serialises a 72-bit display frame into daisy-chained 595-style registers
// and paces digit dwell time. Optional anti-ghosting blank: DISPLAY_BLANK_EN.
module led_shift_driver #(
    parameter int CLK_DIV    = 2,
    parameter int DIGIT_HOLD = 1000,
    parameter int FRAME_W    = display_pkg::FRAME_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] display_bits,
    output logic               timer_overflow,
    output logic               sclk,
    output logic               sdata,
    output logic               sload,
    output logic               sclr_n
);
    import display_pkg::*;

    localparam int HOLD_W = $clog2(DIGIT_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DIGIT_HOLD - 1);

    disp_state_e        state_d, state_q;
    logic [2:0]         seq_d, seq_q;
    logic [HOLD_W-1:0]  hold_d, hold_q;
    logic [6:0]         bit_d, bit_q;
    logic [1:0]         phase_d, phase_q;
    logic [FRAME_W-1:0] shadow_d, shadow_q;
    logic               sclk_d, sclk_q;
    logic               sdata_d, sdata_q;
    logic               sload_d, sload_q;
    logic               sclr_n_d, sclr_n_q;
    logic               ovf_d, ovf_q;
    logic               div_en_s;
    logic               tick_s;

    assign div_en_s = (state_q == ST_BLANK) || (state_q == ST_SHIFT) || (state_q == ST_LOAD);

    sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (div_en_s),
        .restart (state_q == ST_CAPTURE),
        .tick    (tick_s)
    );

    // Sequencer next state; outputs are decoded from the next state so the
    // registered pins line up exactly with the state they belong to.
    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        hold_d   = hold_q;
        bit_d    = bit_q;
        phase_d  = phase_q;
        shadow_d = shadow_q;
        case (state_q)
            ST_CLEAR: begin
                if (seq_q == 3'(CLEAR_CYCLES - 1)) begin
                    state_d = ST_SETTLE;
                    seq_d   = 3'd0;
                end else begin
                    seq_d = seq_q + 3'd1;
                end
            end
            ST_SETTLE: begin
                if (seq_q == 3'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_CAPTURE;
                    seq_d   = 3'd0;
                end else begin
                    seq_d = seq_q + 3'd1;
                end
            end
            ST_CAPTURE: begin
                shadow_d = display_bits;
                bit_d    = 7'(FRAME_W - 1);
                phase_d  = 2'd0;
`ifdef DISPLAY_BLANK_EN
                state_d  = ST_BLANK;
`else
                state_d  = ST_SHIFT;
`endif
            end
`ifdef DISPLAY_BLANK_EN
            // Four quarter-slots: two with the chain cleared, two latching zeros.
            ST_BLANK: begin
                if (tick_s) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_BLANK;
                    end
                end else begin
                    phase_d = phase_q;
                end
            end
`endif
            ST_SHIFT: begin
                if (!tick_s) begin
                    phase_d = phase_q;
                end else if (!phase_q[0]) begin
                    phase_d = 2'd1;
                end else if (bit_q == 7'd0) begin
                    phase_d = 2'd0;
                    state_d = ST_LOAD;
                end else begin
                    phase_d = 2'd0;
                    bit_d   = bit_q - 7'd1;
                end
            end
            ST_LOAD: begin
                if (!tick_s) begin
                    phase_d = phase_q;
                end else if (phase_q[0]) begin
                    phase_d = 2'd0;
                    hold_d  = '0;
                    state_d = ST_HOLD;
                end else begin
                    phase_d = 2'd1;
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    seq_d   = 3'd0;
                    state_d = ST_SETTLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_CLEAR;
                seq_d   = 3'd0;
            end
        endcase

        sclk_d   = (state_d == ST_SHIFT) && phase_d[0];
        sdata_d  = (state_d == ST_SHIFT) ? shadow_d[bit_d] : 1'b0;
        sload_d  = (state_d == ST_LOAD) || ((state_d == ST_BLANK) && phase_d[1]);
        sclr_n_d = !((state_d == ST_CLEAR) || ((state_d == ST_BLANK) && !phase_d[1]));
        ovf_d    = (state_d == ST_HOLD) && (hold_d == HOLD_LAST);
    end

    // State, counters, shadow frame and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_CLEAR;
            seq_q    <= 3'd0;
            hold_q   <= '0;
            bit_q    <= 7'd0;
            phase_q  <= 2'd0;
            shadow_q <= '0;
            sclk_q   <= 1'b0;
            sdata_q  <= 1'b0;
            sload_q  <= 1'b0;
            sclr_n_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            seq_q    <= seq_d;
            hold_q   <= hold_d;
            bit_q    <= bit_d;
            phase_q  <= phase_d;
            shadow_q <= shadow_d;
            sclk_q   <= sclk_d;
            sdata_q  <= sdata_d;
            sload_q  <= sload_d;
            sclr_n_q <= sclr_n_d;
            ovf_q    <= ovf_d;
        end
    end

    assign sclk           = sclk_q;
    assign sdata          = sdata_q;
    assign sload          = sload_q;
    assign sclr_n         = sclr_n_q;
    assign timer_overflow = ovf_q;

endmodule

// File: tb/tb_led_shift_driver.sv
// Directed self-checking bench for led_shift_driver at CLK_DIV=2, DIGIT_HOLD=1000.
// Expectations follow DISPLAY_BLANK_EN when the macro is defined.
module tb_led_shift_driver;

    localparam logic [71:0] P1 = 72'h80_0000_0000_0000_0001;
    localparam logic [71:0] P2 = 72'hA5_C3F0_0F96_1234_5678;
    localparam logic [71:0] P3 = 72'h3C_DEAD_BEEF_0123_4567;
`ifdef DISPLAY_BLANK_EN
    localparam bit BLANK_ON   = 1'b1;
    localparam int FIRST_RISE = 18;
    localparam int FIRST_OVF  = 1307;
    localparam int PERIOD     = 1304;
`else
    localparam bit BLANK_ON   = 1'b0;
    localparam int FIRST_RISE = 10;
    localparam int FIRST_OVF  = 1299;
    localparam int PERIOD     = 1296;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [71:0] display_bits = 72'd0;
    logic        timer_overflow, sclk, sdata, sload, sclr_n;
    int          checks = 0;
    int          errors = 0;

    led_shift_driver #(.CLK_DIV(2), .DIGIT_HOLD(1000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .display_bits   (display_bits),
        .timer_overflow (timer_overflow),
        .sclk           (sclk),
        .sdata          (sdata),
        .sload          (sload),
        .sclr_n         (sclr_n)
    );

    always #5 clk = ~clk;

    // Reset pulse released on a falling edge: the next rising edge is cycle 1.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Observes one frame from just after reset release up to the end of its latch pulse.
    task automatic capture_frame(input bit toggle, output logic [71:0] data, output int rises,
                                 output int load_len, output int overlap, output int partial,
                                 output bit timeout);
        logic prev_sclk;
        bit   done;
        data = 72'd0; rises = 0; load_len = 0; overlap = 0; partial = 0;
        timeout = 1'b1; prev_sclk = 1'b0; done = 1'b0;
        for (int cyc = 1; cyc <= 3000 && !done; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (toggle && cyc >= 8 && ((cyc - 8) % 7) == 0) display_bits = ~display_bits;
            if (sclk && sload) overlap++;
            if (sclk && !prev_sclk) begin
                rises++;
                data = {data[70:0], sdata};
            end
            if (sload && rises > 0 && rises < 72) partial++;
            if (sload && rises > 0) load_len++;
            if (!sload && load_len > 0) begin
                done = 1'b1;
                timeout = 1'b0;
            end
            prev_sclk = sclk;
        end
    endtask

    task automatic test_reset();
        display_bits = P1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL reset_sdata: got %b want 0", sdata); end
        checks++; if (sload !== 1'b0) begin errors++; $display("FAIL reset_sload: got %b want 0", sload); end
        checks++; if (sclr_n !== 1'b0) begin errors++; $display("FAIL reset_sclr_n: got %b want 0", sclr_n); end
        checks++; if (timer_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", timer_overflow); end
        rst_n = 1'b1;
        for (int cyc = 1; cyc <= FIRST_RISE; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 3) begin
                checks++; if (sclr_n !== 1'b0) begin errors++; $display("FAIL clr_held: cycle 3 sclr_n=%b want 0", sclr_n); end
            end
            if (cyc == 4) begin
                checks++; if (sclr_n !== 1'b1) begin errors++; $display("FAIL clr_release: cycle 4 sclr_n=%b want 1", sclr_n); end
            end
            if (cyc == FIRST_RISE - 1) begin
                checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL early_sclk: cycle %0d sclk=%b want 0", cyc, sclk); end
            end
            if (cyc == FIRST_RISE) begin
                checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL first_rise: cycle %0d sclk=%b want 1", cyc, sclk); end
            end
        end
    endtask

    task automatic test_frame();
        logic [71:0] data;
        int rises, load_len, overlap, partial;
        bit to;
        display_bits = P1;
        do_reset();
        capture_frame(1'b0, data, rises, load_len, overlap, partial, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL frame_timeout: no completed frame"); end
        checks++; if (rises != 72) begin errors++; $display("FAIL frame_rises: got %0d want 72", rises); end
        checks++; if (data !== P1) begin errors++; $display("FAIL frame_data: got %h want %h", data, P1); end
        checks++; if (load_len != 4) begin errors++; $display("FAIL frame_load_len: got %0d want 4", load_len); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL frame_overlap: %0d cycles with sclk&sload", overlap); end
    endtask

    task automatic test_no_tearing();
        logic [71:0] data;
        int rises, load_len, overlap, partial;
        bit to;
        display_bits = P2;
        do_reset();
        capture_frame(1'b1, data, rises, load_len, overlap, partial, to);
        checks++; if (rises != 72) begin errors++; $display("FAIL tear_rises: got %0d want 72", rises); end
        checks++; if (data !== P2) begin errors++; $display("FAIL tear_data: got %h want %h", data, P2); end
    endtask

    task automatic test_reset_midshift();
        logic [71:0] data;
        int rises, load_len, overlap, partial;
        bit to, prev_sclk, hit;
        display_bits = P3;
        do_reset();
        rises = 0; prev_sclk = 1'b0; hit = 1'b0;
        for (int cyc = 1; cyc <= 400 && !hit; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (sclk && !prev_sclk) rises++;
            prev_sclk = sclk;
            if (rises == 30) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL mid_reach: saw %0d rises, want 30", rises); end
        rst_n = 1'b0;
        #1;
        checks++; if ({sclk, sdata, sload, sclr_n, timer_overflow} !== 5'b00000) begin
            errors++; $display("FAIL mid_async: outputs %b want 00000", {sclk, sdata, sload, sclr_n, timer_overflow});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        capture_frame(1'b0, data, rises, load_len, overlap, partial, to);
        checks++; if (rises != 72) begin errors++; $display("FAIL mid_rises: got %0d want 72", rises); end
        checks++; if (data !== P3) begin errors++; $display("FAIL mid_data: got %h want %h", data, P3); end
        checks++; if (partial != 0) begin errors++; $display("FAIL mid_partial_load: %0d early sload cycles", partial); end
        checks++; if (load_len != 4) begin errors++; $display("FAIL mid_load_len: got %0d want 4", load_len); end
    endtask

    task automatic test_blank();
        do_reset();
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 7) begin
                checks++; if (sclr_n !== 1'b1) begin errors++; $display("FAIL blank_capture_clr: sclr_n=%b want 1", sclr_n); end
            end
            if (cyc >= 8 && cyc <= 11) begin
                checks++; if (sclr_n !== !BLANK_ON) begin errors++; $display("FAIL blank_clr: cycle %0d sclr_n=%b want %b", cyc, sclr_n, !BLANK_ON); end
            end
            if (cyc >= 12 && cyc <= 15) begin
                checks++; if (sload !== BLANK_ON) begin errors++; $display("FAIL blank_load: cycle %0d sload=%b want %b", cyc, sload, BLANK_ON); end
            end
            if (cyc == 15 && BLANK_ON) begin
                checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL blank_sclk: sclk=%b want 0", sclk); end
            end
        end
    endtask

    task automatic test_overflow();
        int t[5];
        int n, wide;
        logic prev;
        display_bits = P2;
        do_reset();
        n = 0; wide = 0; prev = 1'b0;
        for (int cyc = 1; cyc <= FIRST_OVF + 4 * PERIOD + 20; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (timer_overflow && prev) wide++;
            if (timer_overflow && !prev && n < 5) begin
                t[n] = cyc;
                n++;
            end
            prev = timer_overflow;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL ovf_count: got %0d want 5", n); end
        checks++; if (wide != 0) begin errors++; $display("FAIL ovf_width: %0d extra high cycles", wide); end
        if (n > 0) begin
            checks++; if (t[0] != FIRST_OVF) begin errors++; $display("FAIL ovf_first: cycle %0d want %0d", t[0], FIRST_OVF); end
        end
        for (int i = 1; i < n; i++) begin
            checks++; if (t[i] - t[i-1] != PERIOD) begin
                errors++; $display("FAIL ovf_spacing: gap %0d got %0d want %0d", i, t[i] - t[i-1], PERIOD);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_no_tearing();
        test_reset_midshift();
        test_blank();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_shift_driver.md
Name: led_shift_driver

Overview:
- Downstream stage of the front-panel display multiplexer.
- Takes the 72-bit frame (3 rows × {8 cathode bits, 16 segment bits}) and serialises it into the daisy-chained 595-style shift registers: sclk/sdata, then a latch pulse (sload).
- Emits a one-cycle timer_overflow pulse when the digit's dwell time ends, so the multiplexer advances to the next digit.
- Sole owner of the physical serial bus.

Parameters:
- CLK_DIV, 2: clk cycles per sclk half-period; must be ≥1.
- DIGIT_HOLD, 1000: clk cycles the latched digit is displayed before timer_overflow; must be ≥1.
- FRAME_W, 72: bits shifted per digit; equals 3 × ROW_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- display_bits  in  72  frame from multiplexer; bit 71 shifted first
- timer_overflow  out  1  one-cycle pulse, last cycle of HOLD
- sclk  out  1  shift clock; registers sample sdata on rising edge
- sdata  out  1  serial data
- sload  out  1  storage-register latch, active-high
- sclr_n  out  1  shift-register clear, active-low

Behaviour:
- All outputs registered.
- Reset values: sclk=0, sdata=0, sload=0, sclr_n=0, timer_overflow=0, state=CLEAR.
- CLEAR: 4 cycles, sclr_n=0; then sclr_n=1 → SETTLE.
- SETTLE: 3 cycles.
  - Covers the multiplexer's state update plus row-register update after timer_overflow.
  - Then → CAPTURE.
- CAPTURE: 1 cycle.
  - Snapshot display_bits into shadow register; bit counter=71; div counter=0.
  - → SHIFT.
- SHIFT: per bit, two phases of CLK_DIV cycles each.
  - Low phase: sclk=0, sdata=shadow[bit] from its first cycle.
  - High phase: sclk=1, sdata held.
  - After bit 0's high phase → LOAD.
  - Exactly 72 sclk rising edges per frame.
  - Duration: 72 × 2 × CLK_DIV cycles.
- LOAD: sclk=0, sdata=0, sload=1 for 2 × CLK_DIV cycles → HOLD.
- HOLD: DIGIT_HOLD cycles.
  - timer_overflow=1 only in the last HOLD cycle.
  - Then → SETTLE.
- Frame period, steady state: 4 + 146 × CLK_DIV + DIGIT_HOLD cycles (1296 at defaults).
- Frame period, first frame after reset: 4 additional CLEAR cycles.
- display_bits changes outside CAPTURE are ignored; no tearing mid-shift.
- Counter widths:
  - Bit counter: 7 bits.
  - Div counter: clog2(CLK_DIV) bits, min 1.
  - Hold counter: clog2(DIGIT_HOLD+1) bits.
  - Counters never wrap; terminal counts are compared explicitly.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous); restart at CLEAR on release.
- sload and sclk are never high simultaneously.
- sdata is stable for a full half-period on either side of each sclk rising edge.

Optional Feature:
- Macro DISPLAY_BLANK_EN (anti-ghosting blank).
- Defined:
  - BLANK state inserted between CAPTURE and SHIFT.
  - sclr_n=0 for 2 × CLK_DIV cycles, then sload=1 for 2 × CLK_DIV cycles, latching all-zeros so LEDs are dark during the shift.
  - Period grows by 4 × CLK_DIV (1304 at defaults).
- Undefined: BLANK state absent; sclr_n=0 only in CLEAR; old digit stays lit during the shift.

Decomposition:
- Shared package display_pkg:
  - ROW_W=24, FRAME_W=72.
  - State encoding: CLEAR, SETTLE, CAPTURE, BLANK, SHIFT, LOAD, HOLD.
  - CLEAR_CYCLES=4, SETTLE_CYCLES=3.
- One sub-module: sclk_tick_gen.
  - Div counter producing a one-cycle tick every CLK_DIV cycles; restartable.
  - Used for SHIFT phases and LOAD/BLANK widths.

Test Plan (CLK_DIV=2, DIGIT_HOLD=1000):
- Reset release:
  - All outputs 0 during reset.
  - sclr_n rises 4 cycles after release.
  - First sclk rise 8 + 2 = 10 cycles after release.
- display_bits=72'h80_0000_0000_0000_0001:
  - sdata=1 at sclk rising edges 1 and 72 only.
  - Exactly 72 rises.
  - Then sload high 4 cycles with sclk=0.
- Free run 5 frames: timer_overflow pulses 1 cycle wide, spaced exactly 1296 cycles.
- Toggle display_bits every 7 cycles during SHIFT: serial stream equals the CAPTURE-cycle snapshot bit-for-bit.
- Assert rst_n low at sclk rise 30:
  - Outputs reset within the same cycle.
  - After release, CLEAR then a full 72-bit frame; no partial sload.
- DISPLAY_BLANK_EN defined:
  - After CAPTURE, sclr_n low 4 cycles, then sload high 4 cycles, before the first sclk rise.
  - Overflow spacing 1304.
